// File: rtl/uart_sampled_rx.sv
// uart_sampled_rx: 16x oversampled UART receiver with 3-sample majority vote,
// framing/overrun detection and a valid/ready byte output.
// Optional parity support is compiled in with `define UART_RX_PARITY_EN, which
// adds parameter PARITY_ODD and output parity_err.
module uart_sampled_rx #(
   parameter int CLOCK_FREQ  = 100000000,
   parameter int BAUD_RATE   = 9600,
   parameter int DBIT        = 8,
   parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD  = 1'b0
`endif
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rx,
   output logic [DBIT-1:0] rx_data,
   output logic            rx_valid,
   input  logic            rx_ready,
   output logic            rx_done_tick,
   output logic            frame_err,
   output logic            overrun_err,
`ifdef UART_RX_PARITY_EN
   output logic            parity_err,
`endif
   output logic            busy
);

   localparam int DIV_RAW = CLOCK_FREQ / (BAUD_RATE * 16);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int NW      = $clog2(DBIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs, rxs_prev_q;
   state_t                 state_q, state_d;
   logic [TW-1:0]          tcnt_q, tcnt_d;
   logic [3:0]             s_q, s_d;
   logic [NW-1:0]          n_q, n_d;
   logic                   v7_q, v7_d, v8_q, v8_d;
   logic [DBIT-1:0]        shreg_q, shreg_d;
   logic [DBIT-1:0]        data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   done_q, done_d, ferr_q, ferr_d, ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
   logic                   par_q, par_d, perr_q, perr_d;
`endif
   logic                   tick, fall, vote;

   assign rxs  = sync_q[SYNC_STAGES-1];
   assign tick = (tcnt_q == TW'(DIV - 1));
   assign fall = rxs_prev_q & ~rxs;
   // Majority of the samples taken at s=7, s=8 and the current one (s=9).
   assign vote = (v7_q & v8_q) | (v7_q & rxs) | (v8_q & rxs);

   // Input synchronizer and edge-detect history; idle-high preset avoids a false edge out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= '1;
         rxs_prev_q <= 1'b1;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
         rxs_prev_q <= rxs;
      end
   end

   // Next-state logic: oversample timing, frame FSM, delivery and handshake.
   always_comb begin
      state_d = state_q;
      tcnt_d  = tick ? '0 : tcnt_q + TW'(1);
      s_d     = s_q;
      n_d     = n_q;
      v7_d    = v7_q;
      v8_d    = v8_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif
      if (valid_q && rx_ready) valid_d = 1'b0;
      if (tick) begin
         if (s_q == 4'd7) v7_d = rxs;
         if (s_q == 4'd8) v8_d = rxs;
         s_d = s_q + 4'd1;
      end
      case (state_q)
         S_IDLE: begin
            // Restart the tick divider so sample points sit relative to the start edge.
            if (fall) begin
               state_d = S_START;
               tcnt_d  = '0;
               s_d     = 4'd0;
            end
         end
         S_START: begin
            // The start bit is confirmed at s=9; DATA begins at the bit boundary so
            // the bit index only advances on data-bit boundaries.
            if (tick && s_q == 4'd9 && vote) begin
               state_d = S_IDLE;
            end else if (tick && s_q == 4'd15) begin
               state_d = S_DATA;
               n_d     = '0;
            end
         end
         S_DATA: begin
            if (tick && s_q == 4'd9) shreg_d[n_q] = vote;
            if (tick && s_q == 4'd15) begin
               if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  n_d = n_q + NW'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (tick && s_q == 4'd9) par_d = vote;
            if (tick && s_q == 4'd15) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (tick && s_q == 4'd9) begin
               state_d = S_IDLE;
               if (!vote) begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
                  s_d     = 4'd0;
`ifdef UART_RX_PARITY_EN
               end else if (((^shreg_q) ^ par_q) != PARITY_ODD) begin
                  perr_d = 1'b1;
`endif
               end else if (!valid_q || rx_ready) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  ovr_d = 1'b1;
               end
            end
         end
         S_BREAK: begin
            // s counts consecutive high ticks here; any low sample starts over.
            if (tick) begin
               if (!rxs) s_d = 4'd0;
               else if (s_q == 4'd15) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         tcnt_q  <= '0;
         s_q     <= '0;
         n_q     <= '0;
         v7_q    <= 1'b1;
         v8_q    <= 1'b1;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         s_q     <= s_d;
         n_q     <= n_d;
         v7_q    <= v7_d;
         v8_q    <= v8_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_done_tick = done_q;
   assign frame_err    = ferr_q;
   assign overrun_err  = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err   = perr_q;
`endif
   assign busy         = (state_q != S_IDLE);

endmodule
